// File: rtl/seg_p2s_pkg.sv
// rtl/seg_p2s_pkg.sv - shared types and frame geometry for the seven-segment serializer
package seg_p2s_pkg;

  localparam int FRAME_BITS = 64;
  localparam int DIGIT_BITS = 8;
  localparam int BIT_CNT_W  = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_SHIFT = 2'd2,
    ST_LATCH = 2'd3
  } state_t;

endpackage

// File: rtl/seg_p2s_tick.sv
// rtl/seg_p2s_tick.sv - half-period divider, one-cycle tick every HALF_CYC enabled cycles
module seg_p2s_tick #(
  parameter int HALF_CYC = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = $clog2(HALF_CYC + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(HALF_CYC - 1);

  logic [CNT_W-1:0] cnt;

  // Count enabled cycles, wrapping to zero on the last cycle of each half period.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/seg_p2s.sv
// rtl/seg_p2s.sv - 64-bit frame serializer for a shift-register segment display chain; optional SEG_P2S_AUTO_REFRESH_EN
module seg_p2s
  import seg_p2s_pkg::*;
#(
  parameter int HALF_CYC = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [FRAME_BITS-1:0] seg_txt,
  output logic                  seg_clk,
  output logic                  seg_dout,
  output logic                  seg_clrn,
  output logic                  seg_pen,
  output logic                  busy,
  output logic                  done
);

  localparam int NUM_DIGITS = FRAME_BITS / DIGIT_BITS;
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(NUM_DIGITS * DIGIT_BITS - 1);

  state_t                state_q, state_d;
  logic [FRAME_BITS-1:0] shadow_q, shadow_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic                  phase_q, phase_d;
  logic                  seg_clk_d, seg_dout_d, seg_clrn_d, seg_pen_d, busy_d, done_d;
  logic                  go;
  logic                  tick_en;
  logic                  tick;
  logic [5:0]            next_idx;

`ifdef SEG_P2S_AUTO_REFRESH_EN
  logic [FRAME_BITS-1:0] copy_q;

  // Remember the frame just shifted so a changed input can trigger a refresh.
  always_ff @(posedge clk) begin
    if (rst) begin
      copy_q <= '0;
    end else if (state_q == ST_LATCH) begin
      copy_q <= shadow_q;
    end
  end

  assign go = start | (seg_txt != copy_q);
`else
  assign go = start;
`endif

  assign tick_en  = (state_q == ST_CLEAR) || (state_q == ST_SHIFT);
  assign next_idx = bit_cnt_q[5:0] + 6'd1;

  seg_p2s_tick #(
    .HALF_CYC(HALF_CYC)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .en  (tick_en),
    .tick(tick)
  );

  // Next state and next registered output values; everything holds unless a rule changes it.
  always_comb begin
    state_d    = state_q;
    shadow_d   = shadow_q;
    bit_cnt_d  = bit_cnt_q;
    phase_d    = phase_q;
    seg_clk_d  = seg_clk;
    seg_dout_d = seg_dout;
    seg_clrn_d = seg_clrn;
    seg_pen_d  = seg_pen;
    busy_d     = busy;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        seg_clrn_d = 1'b1;
        seg_clk_d  = 1'b0;
        busy_d     = 1'b0;
        if (go) begin
          shadow_d   = seg_txt;
          state_d    = ST_CLEAR;
          busy_d     = 1'b1;
          seg_pen_d  = 1'b0;
          seg_clrn_d = 1'b0;
          bit_cnt_d  = '0;
          phase_d    = 1'b0;
        end
      end
      ST_CLEAR: begin
        if (tick) begin
          state_d    = ST_SHIFT;
          seg_clrn_d = 1'b1;
          seg_clk_d  = 1'b0;
          seg_dout_d = shadow_q[0];
          bit_cnt_d  = '0;
          phase_d    = 1'b0;
        end
      end
      ST_SHIFT: begin
        if (tick) begin
          if (!phase_q) begin
            seg_clk_d = 1'b1;
            phase_d   = 1'b1;
          end else if (bit_cnt_q == LAST_BIT) begin
            seg_clk_d = 1'b0;
            state_d   = ST_LATCH;
          end else begin
            seg_clk_d  = 1'b0;
            phase_d    = 1'b0;
            bit_cnt_d  = bit_cnt_q + BIT_CNT_W'(1);
            seg_dout_d = shadow_q[next_idx];
          end
        end
      end
      ST_LATCH: begin
        seg_clk_d = 1'b0;
        seg_pen_d = 1'b1;
        done_d    = 1'b1;
        busy_d    = 1'b0;
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, datapath and output registers; reset forces the chain cleared and display blanked.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      shadow_q  <= '0;
      bit_cnt_q <= '0;
      phase_q   <= 1'b0;
      seg_clk   <= 1'b0;
      seg_dout  <= 1'b0;
      seg_clrn  <= 1'b0;
      seg_pen   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      bit_cnt_q <= bit_cnt_d;
      phase_q   <= phase_d;
      seg_clk   <= seg_clk_d;
      seg_dout  <= seg_dout_d;
      seg_clrn  <= seg_clrn_d;
      seg_pen   <= seg_pen_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

endmodule

// File: tb/tb_seg_p2s.sv
// tb/tb_seg_p2s.sv - self-checking bench for seg_p2s (HALF_CYC=2 and HALF_CYC=1 instances)
module tb_seg_p2s;

  logic        clk = 1'b0;
  logic        rst_v   [2];
  logic        start_v [2];
  logic [63:0] txt_v   [2];
  logic        sclk    [2];
  logic        sdout   [2];
  logic        sclrn   [2];
  logic        spen    [2];
  logic        sbusy   [2];
  logic        sdone   [2];

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;

  logic [63:0] rx        [2];
  int          rx_n      [2];
  int          clrn_lo   [2];
  int          ones      [2];
  int          done_cnt  [2];
  int          last_done [2];
  logic        sclk_prev [2];
  int          done_log1 [$];

  always #5 clk = ~clk;

  // Cycle index: after posedge N the value is N.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int HC = (g == 0) ? 2 : 1;

    seg_p2s #(.HALF_CYC(HC)) u_dut (
      .clk     (clk),
      .rst     (rst_v[g]),
      .start   (start_v[g]),
      .seg_txt (txt_v[g]),
      .seg_clk (sclk[g]),
      .seg_dout(sdout[g]),
      .seg_clrn(sclrn[g]),
      .seg_pen (spen[g]),
      .busy    (sbusy[g]),
      .done    (sdone[g])
    );

    // Reference model: outputs as a function of the offset t from the start-sampling edge.
    // Vector order is {seg_clk, seg_dout, seg_clrn, seg_pen, busy, done}.
    bit          active = 1'b0;
    int          t = 0;
    logic [63:0] data = '0;
    logic [63:0] copy = '0;
    logic        pen_e = 1'b0;
    logic        dout_e = 1'b0;
    logic [5:0]  exp_v = '0;

    always @(posedge clk) begin
      logic go;
      int   k, w;
      go = start_v[g];
`ifdef SEG_P2S_AUTO_REFRESH_EN
      go = go | (txt_v[g] != copy);
`endif
      if (rst_v[g]) begin
        active = 1'b0;
        pen_e  = 1'b0;
        dout_e = 1'b0;
        copy   = '0;
        exp_v  = 6'b000000;
      end else if (active) begin
        t = t + 1;
        if (t < HC) begin
          exp_v = {1'b0, dout_e, 1'b0, pen_e, 1'b1, 1'b0};
        end else if (t < 129 * HC) begin
          k      = (t - HC) / (2 * HC);
          w      = (t - HC) % (2 * HC);
          dout_e = data[k];
          exp_v  = {(w >= HC) ? 1'b1 : 1'b0, dout_e, 1'b1, pen_e, 1'b1, 1'b0};
        end else if (t == 129 * HC) begin
          exp_v = {1'b0, dout_e, 1'b1, pen_e, 1'b1, 1'b0};
        end else begin
          active = 1'b0;
          pen_e  = 1'b1;
          copy   = data;
          exp_v  = {1'b0, dout_e, 1'b1, 1'b1, 1'b0, 1'b1};
        end
      end else if (go) begin
        active = 1'b1;
        t      = 0;
        data   = txt_v[g];
        pen_e  = 1'b0;
        exp_v  = {1'b0, dout_e, 1'b0, 1'b0, 1'b1, 1'b0};
      end else begin
        exp_v = {1'b0, dout_e, 1'b1, pen_e, 1'b0, 1'b0};
      end
    end

    // Per-cycle compare against the model plus observation of the serial stream.
    always @(negedge clk) begin
      check($sformatf("cycle%0d_dut%0d", cyc, g),
            {58'd0, sclk[g], sdout[g], sclrn[g], spen[g], sbusy[g], sdone[g]}, {58'd0, exp_v});
      if (sclk[g] && !sclk_prev[g]) begin
        rx[g]   = {sdout[g], rx[g][63:1]};
        rx_n[g] = rx_n[g] + 1;
      end
      sclk_prev[g] = sclk[g];
      if (!sclrn[g] && !rst_v[g]) clrn_lo[g] = clrn_lo[g] + 1;
      if (sdout[g] && sbusy[g]) ones[g] = ones[g] + 1;
      if (sdone[g]) begin
        done_cnt[g]  = done_cnt[g] + 1;
        last_done[g] = cyc;
        if (g == 1) done_log1.push_back(cyc);
      end
    end
  end

  task automatic clear_obs();
    rx[0]      = '0;
    rx_n[0]    = 0;
    clrn_lo[0] = 0;
    ones[0]    = 0;
  endtask

  // One start pulse on the HALF_CYC=2 instance, then pin latency, data and clear width.
  task automatic run_frame(input logic [63:0] d, input string nm);
    int st, d0, i;
    txt_v[0] = d;
    clear_obs();
    d0 = done_cnt[0];
    start_v[0] = 1'b1;
    step(1);
    start_v[0] = 1'b0;
    st = cyc;
    i = 0;
    while (done_cnt[0] == d0 && i < 400) begin
      step(1);
      i++;
    end
    check({nm, "_done_seen"}, 64'(done_cnt[0] - d0), 64'd1);
    check({nm, "_latency"}, 64'(last_done[0] - st), 64'(2 + 128 * 2 + 1));
    check({nm, "_data"}, rx[0], d);
    check({nm, "_bits"}, 64'(rx_n[0]), 64'd64);
    check({nm, "_clrn_low"}, 64'(clrn_lo[0]), 64'd2);
    check({nm, "_pen"}, {63'd0, spen[0]}, 64'd1);
  endtask

  initial begin
    logic [63:0] d;
    int st, d0, i;
    for (int g = 0; g < 2; g++) begin
      rst_v[g] = 1'b1; start_v[g] = 1'b0; txt_v[g] = '0;
      rx[g] = '0; rx_n[g] = 0; clrn_lo[g] = 0; ones[g] = 0;
      done_cnt[g] = 0; last_done[g] = 0; sclk_prev[g] = 1'b0;
    end
    step(3);
    check("reset_outs", {58'd0, sclk[0], sdout[0], sclrn[0], spen[0], sbusy[0], sdone[0]}, 64'd0);
    rst_v[0] = 1'b0;
    step(1);
    check("idle_after_reset", {62'd0, sclrn[0], sbusy[0]}, 64'b10);

    // Single set bit: only bit 0 is high on the line, display enabled afterwards.
    run_frame(64'h0000_0000_0000_0001, "s1");
    check("s1_dout_high_cycles", 64'(ones[0]), 64'd4);
    step(5);
    check("s1_pen_holds", {63'd0, spen[0]}, 64'd1);

    run_frame(64'hA5C3_0F0F_FFFF_0000, "s2");

    // Mid-frame start pulses are ignored and a seg_txt change does not corrupt the frame.
    d = 64'h0123_4567_89AB_CDEF;
    txt_v[0] = d;
    clear_obs();
    d0 = done_cnt[0];
    start_v[0] = 1'b1;
    step(1);
    st = cyc;
    for (int k = 1; k < 400 && done_cnt[0] == d0; k++) begin
      start_v[0] = (k == 10 || k == 50);
      if (k == 20) txt_v[0] = ~d;
      if (k == 60) txt_v[0] = d;
      step(1);
    end
    start_v[0] = 1'b0;
    check("s3_latency", 64'(last_done[0] - st), 64'(2 + 128 * 2 + 1));
    check("s3_data", rx[0], d);
    step(300);
    check("s3_one_done", 64'(done_cnt[0] - d0), 64'd1);

    // Reset during bit 30 aborts the frame with no done and a blank display.
    txt_v[0] = 64'hDEAD_BEEF_0BAD_F00D;
    d0 = done_cnt[0];
    start_v[0] = 1'b1;
    step(1);
    start_v[0] = 1'b0;
    step(122);
    rst_v[0] = 1'b1;
    txt_v[0] = '0;
    step(1);
    check("s4_reset_vals", {58'd0, sclk[0], sdout[0], sclrn[0], spen[0], sbusy[0], sdone[0]}, 64'd0);
    rst_v[0] = 1'b0;
    step(400);
    check("s4_no_done", 64'(done_cnt[0] - d0), 64'd0);
    check("s4_pen_low", {63'd0, spen[0]}, 64'd0);
    run_frame(64'h1357_9BDF_2468_ACE0, "s4_new");

    // Random frames with random idle gaps.
    for (int r = 0; r < 3; r++) begin
      step($urandom_range(0, 5));
      run_frame({$urandom, $urandom}, $sformatf("rand%0d", r));
    end

    // Input-change refresh: frame only when the refresh feature is built in.
    rst_v[0] = 1'b1;
    txt_v[0] = '0;
    step(2);
    rst_v[0] = 1'b0;
    step(5);
    d0 = done_cnt[0];
    txt_v[0] = 64'h1;
    step(400);
`ifdef SEG_P2S_AUTO_REFRESH_EN
    check("s6_refresh_frames", 64'(done_cnt[0] - d0), 64'd1);
`else
    check("s6_refresh_frames", 64'(done_cnt[0] - d0), 64'd0);
`endif
    d0 = done_cnt[0];
    step(300);
    check("s6_no_more_frames", 64'(done_cnt[0] - d0), 64'd0);

    // HALF_CYC=1 instance: start held high with random data changing every cycle.
    rst_v[1] = 1'b0;
    start_v[1] = 1'b1;
    step(1);
    st = cyc;
    for (int k = 0; k < 600; k++) begin
      txt_v[1] = {$urandom, $urandom};
      step(1);
    end
    start_v[1] = 1'b0;
    step(300);
    check("s5_frame_count_min4", 64'(done_log1.size() >= 4), 64'd1);
    if (done_log1.size() >= 1)
      check("s5_first_latency", 64'(done_log1[0] - st), 64'(1 + 128 * 1 + 1));
    for (i = 1; i < done_log1.size(); i++)
      check($sformatf("s5_period%0d", i), 64'(done_log1[i] - done_log1[i-1]), 64'd131);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
